// File: rtl/calc_pkg.sv
// Shared definitions for the convolution datapath: controller state codes,
// default datapath widths and a saturating adder reused by the requant stage.
// Latency: n/a (package). Backpressure: n/a.
package calc_pkg;

  localparam int SUM_WIDTH_DEF = 20;
  localparam int ACC_WIDTH_DEF = 24;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  // Saturating add of two signed values that each fit in w bits.
  // Their exact sum needs at most w+1 bits; the 64-bit container holds that
  // for any w up to 62, so one function serves every datapath width.
  // The result is clamped to the signed w-bit range and ovf flags a clamp.
  function automatic logic signed [63:0] sat_add(
    input  logic signed [63:0] a,
    input  logic signed [63:0] b,
    input  int                 w,
    output logic               ovf
  );
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    s   = a + b;
    hi  = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo  = -hi - 64'sd1;
    ovf = 1'b0;
    if (s > hi) begin
      s   = hi;
      ovf = 1'b1;
    end else if (s < lo) begin
      s   = lo;
      ovf = 1'b1;
    end
    return s;
  endfunction

endpackage

// File: rtl/conv_chan_acc_ctrl_sat_acc.sv
// sat_acc: signed accumulator with bias load, add enable, saturation, sticky ovf.
// Latency: one cycle from load/en to acc/ovf. Backpressure: none (enable-driven).
// Ports: clk, rst_n (sync, active-low); load/load_val set acc and clear ovf;
//        en adds sign-extended addend with saturation; acc/ovf are registered.
module sat_acc
  import calc_pkg::*;
#(
  parameter int SUM_WIDTH = SUM_WIDTH_DEF,
  parameter int ACC_WIDTH = ACC_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [ACC_WIDTH-1:0] load_val,
  input  logic                 en,
  input  logic [SUM_WIDTH-1:0] addend,
  output logic [ACC_WIDTH-1:0] acc,
  output logic                 ovf
);

  logic [ACC_WIDTH-1:0] acc_q;
  logic                 ovf_q;
  logic [ACC_WIDTH-1:0] acc_next;
  logic                 sat_hit;

  // Clamped value is the new accumulator, so saturation persists: later
  // contributions of the opposite sign start from the clamp, not the true sum.
  always_comb begin
    sat_hit  = 1'b0;
    acc_next = ACC_WIDTH'(sat_add(64'($signed(acc_q)), 64'($signed(addend)),
                                  ACC_WIDTH, sat_hit));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else if (load) begin
      acc_q <= load_val;
      ovf_q <= 1'b0;
    end else if (en) begin
      acc_q <= acc_next;
      if (sat_hit) begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign acc = acc_q;
  assign ovf = ovf_q;

endmodule

// File: rtl/conv_chan_acc_ctrl.sv
// Sequences the 3x3 dot unit across the input channels of one output pixel
// and accumulates its results with bias and saturation into one pixel.
// Latency: last window fire at t -> out_vld at t+2; out held until out_rdy.
// Ports: cfg_vld/cfg_num_ch/cfg_bias start a pixel (IDLE only); busy;
//        win_vld/win_rdy window handshake; dot_in_vld/dot_ans to/from dot unit;
//        out_vld/out_rdy/out_data/out_ovf result handshake.
module conv_chan_acc_ctrl
  import calc_pkg::*;
#(
  parameter int SUM_WIDTH = SUM_WIDTH_DEF,
  parameter int ACC_WIDTH = ACC_WIDTH_DEF,
  parameter int CH_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_vld,
  input  logic [CH_WIDTH-1:0]  cfg_num_ch,
  input  logic [ACC_WIDTH-1:0] cfg_bias,
  output logic                 busy,
  input  logic                 win_vld,
  output logic                 win_rdy,
  output logic                 dot_in_vld,
  input  logic [SUM_WIDTH-1:0] dot_ans,
  output logic                 out_vld,
  input  logic                 out_rdy,
  output logic [ACC_WIDTH-1:0] out_data,
  output logic                 out_ovf
);

  state_t              state_q;
  state_t              state_d;
  logic [CH_WIDTH-1:0] num_ch_q;
  logic [CH_WIDTH-1:0] issue_q;
  logic                ans_vld_q;
  logic                cfg_take;
  logic                fire;
  logic                last_fire;

  assign cfg_take   = (state_q == ST_IDLE) && cfg_vld;
  assign win_rdy    = (state_q == ST_RUN);
  assign fire       = win_vld && win_rdy;
  assign dot_in_vld = fire;
  assign last_fire  = fire && ((issue_q + CH_WIDTH'(1)) == num_ch_q);
  assign busy       = (state_q != ST_IDLE);
  assign out_vld    = (state_q == ST_OUT);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cfg_vld) begin
          state_d = (cfg_num_ch == '0) ? ST_OUT : ST_RUN;
        end
      end
      ST_RUN: begin
        if (last_fire) begin
          state_d = ST_DRAIN;
        end
      end
      // The final ans lands in this cycle; one cycle is always enough.
      ST_DRAIN: state_d = ST_OUT;
      ST_OUT: begin
        if (out_rdy) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      num_ch_q  <= '0;
      issue_q   <= '0;
      ans_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      // The dot unit's ans is valid exactly one cycle after each fire.
      ans_vld_q <= fire;
      if (cfg_take) begin
        num_ch_q <= cfg_num_ch;
        issue_q  <= '0;
      end else if (fire) begin
        issue_q <= issue_q + CH_WIDTH'(1);
      end
    end
  end

  sat_acc #(
    .SUM_WIDTH(SUM_WIDTH),
    .ACC_WIDTH(ACC_WIDTH)
  ) u_sat_acc (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cfg_take),
    .load_val (cfg_bias),
    .en       (ans_vld_q),
    .addend   (dot_ans),
    .acc      (out_data),
    .ovf      (out_ovf)
  );

endmodule

// File: tb/tb_conv_chan_acc_ctrl.sv
module tb_conv_chan_acc_ctrl;

  localparam int SW = 20;
  localparam int AW = 24;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_vld;
  logic [CW-1:0] cfg_num_ch;
  logic [AW-1:0] cfg_bias;
  logic          busy;
  logic          win_vld;
  logic          win_rdy;
  logic          dot_in_vld;
  logic [SW-1:0] dot_ans;
  logic          out_vld;
  logic          out_rdy;
  logic [AW-1:0] out_data;
  logic          out_ovf;

  int n_tests = 0;
  int n_fail  = 0;
  int pulse_cnt = 0;
  int ans_q[$];
  int exp_d_q[$];
  int exp_o_q[$];

  typedef struct {
    int num_ch;
    int bias;
    int kind;
    int gap;
    int hold;
    int cfg_mid;
    int exp_data;
    int exp_ovf;
  } vec_t;

  vec_t tbl[8];

  always #5 clk = ~clk;

  conv_chan_acc_ctrl #(.SUM_WIDTH(SW), .ACC_WIDTH(AW), .CH_WIDTH(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_vld    (cfg_vld),
    .cfg_num_ch (cfg_num_ch),
    .cfg_bias   (cfg_bias),
    .busy       (busy),
    .win_vld    (win_vld),
    .win_rdy    (win_rdy),
    .dot_in_vld (dot_in_vld),
    .dot_ans    (dot_ans),
    .out_vld    (out_vld),
    .out_rdy    (out_rdy),
    .out_data   (out_data),
    .out_ovf    (out_ovf)
  );

  // Dot-unit stand-in: ans appears the cycle after a fire; on other cycles it
  // carries junk, which the controller must ignore.
  always @(posedge clk) begin
    if (dot_in_vld === 1'b1) begin
      pulse_cnt <= pulse_cnt + 1;
      if (ans_q.size() > 0) dot_ans <= SW'(ans_q.pop_front());
      else dot_ans <= SW'($urandom);
    end else begin
      dot_ans <= SW'($urandom);
    end
  end

  function automatic int ans_val(input int kind, input int i);
    int a3[3];
    int p4[3];
    int n2[2];
    a3 = '{100, -50, 7};
    p4 = '{147456, -100, 5};
    n2 = '{-100, 50};
    case (kind)
      0: return a3[i % 3];
      1: return 147456;
      2: return -146304;
      3: return i + 1;
      4: return p4[i % 3];
      default: return n2[i % 2];
    endcase
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_pixel(input vec_t v);
    int base;
    int tmo;
    int ed;
    int eo;
    exp_d_q.push_back(v.exp_data);
    exp_o_q.push_back(v.exp_ovf);
    for (int i = 0; i < v.num_ch; i++) ans_q.push_back(ans_val(v.kind, i));
    check("idle_before_cfg", longint'(busy), 0);
    base = pulse_cnt;
    cfg_vld    = 1'b1;
    cfg_num_ch = v.num_ch[CW-1:0];
    cfg_bias   = v.bias[AW-1:0];
    step();
    cfg_vld    = 1'b0;
    cfg_num_ch = CW'($urandom);
    cfg_bias   = AW'($urandom);
    check("busy_after_cfg", longint'(busy), 1);
    if (v.num_ch == 0) begin
      check("zero_ch_win_rdy", longint'(win_rdy), 0);
      check("zero_ch_out_next", longint'(out_vld), 1);
    end else begin
      for (int i = 0; i < v.num_ch; i++) begin
        if (v.gap > 0 && i > 0) begin
          win_vld = 1'b0;
          for (int g = 0; g < v.gap; g++) step();
          check("gap_keeps_run", longint'(win_rdy), 1);
        end
        win_vld = 1'b1;
        if (v.cfg_mid != 0 && i == 1) begin
          cfg_vld    = 1'b1;
          cfg_num_ch = 8'd1;
          cfg_bias   = 24'd12345;
        end
        tmo = 0;
        while (win_rdy !== 1'b1 && tmo < 20) begin
          step();
          tmo++;
        end
        if (tmo == 20) check("win_rdy_timeout", 0, 1);
        step();
        cfg_vld = 1'b0;
      end
      // Continuous-valid pixels keep win_vld high through DRAIN/OUT.
      if (v.gap > 0) win_vld = 1'b0;
      check("drain_no_out", longint'(out_vld), 0);
      check("drain_win_rdy", longint'(win_rdy), 0);
      step();
      check("out_latency", longint'(out_vld), 1);
    end
    out_rdy = 1'b0;
    for (int h = 0; h < v.hold; h++) begin
      check("hold_vld", longint'(out_vld), 1);
      check("hold_data", longint'($signed(out_data)), longint'(v.exp_data));
      step();
    end
    tmo = 0;
    while (out_vld !== 1'b1 && tmo < 20) begin
      step();
      tmo++;
    end
    if (tmo == 20) check("out_vld_timeout", 0, 1);
    out_rdy = 1'b1;
    ed = exp_d_q.pop_front();
    eo = exp_o_q.pop_front();
    check("out_data", longint'($signed(out_data)), longint'(ed));
    check("out_ovf", longint'(out_ovf), longint'(eo));
    step();
    out_rdy = 1'b0;
    win_vld = 1'b0;
    check("after_hs_out_vld", longint'(out_vld), 0);
    check("after_hs_idle", longint'(busy), 0);
    check("fire_count", longint'(pulse_cnt - base), longint'(v.num_ch));
  endtask

  initial begin
    tbl[0] = '{3, 10, 0, 0, 0, 0, 67, 0};
    tbl[1] = '{3, 10, 0, 2, 5, 0, 67, 0};
    tbl[2] = '{60, 0, 1, 0, 0, 0, 8388607, 1};
    tbl[3] = '{60, 0, 2, 0, 0, 0, -8388608, 1};
    tbl[4] = '{0, -5, 0, 0, 0, 0, -5, 0};
    tbl[5] = '{4, 1000, 3, 0, 0, 1, 1010, 0};
    tbl[6] = '{3, 8388000, 4, 0, 0, 0, 8388512, 1};
    tbl[7] = '{2, -8388600, 5, 1, 2, 0, -8388558, 1};

    rst_n      = 1'b0;
    cfg_vld    = 1'b1;
    cfg_num_ch = 8'd3;
    cfg_bias   = 24'd10;
    win_vld    = 1'b1;
    out_rdy    = 1'b1;
    step();
    step();
    check("rst_busy", longint'(busy), 0);
    check("rst_win_rdy", longint'(win_rdy), 0);
    check("rst_dot_in_vld", longint'(dot_in_vld), 0);
    check("rst_out_vld", longint'(out_vld), 0);
    check("rst_out_data", longint'(out_data), 0);
    check("rst_out_ovf", longint'(out_ovf), 0);
    check("rst_no_fire", longint'(pulse_cnt), 0);
    cfg_vld = 1'b0;
    win_vld = 1'b0;
    out_rdy = 1'b0;
    rst_n   = 1'b1;
    step();

    for (int t = 0; t < 8; t++) run_pixel(tbl[t]);

    // Reset in the middle of RUN drops the pixel with no output.
    ans_q.push_back(1);
    ans_q.push_back(2);
    cfg_vld    = 1'b1;
    cfg_num_ch = 8'd4;
    cfg_bias   = 24'd0;
    step();
    cfg_vld = 1'b0;
    win_vld = 1'b1;
    step();
    step();
    win_vld = 1'b0;
    rst_n   = 1'b0;
    step();
    rst_n = 1'b1;
    ans_q.delete();
    check("midrst_idle", longint'(busy), 0);
    for (int k = 0; k < 5; k++) begin
      check("midrst_no_out", longint'(out_vld), 0);
      step();
    end
    run_pixel(tbl[0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/conv_chan_acc_ctrl.md
Name: conv_chan_acc_ctrl

Overview:
Sequences the 3x3 int8 dot-product unit (`inner_dot_T2_utility`) across the input channels of one output pixel. It accepts per-channel 3x3 windows over a valid/ready handshake and drives the dot unit's `in_vld`. It accumulates the unit's `ans` outputs with a programmed bias and saturation, then presents one output pixel over a valid/ready handshake. It sits between the window/weight fetch logic and the requantisation stage.

Parameters:
- SUM_WIDTH, 20: width of the dot unit's `ans` (signed).
- ACC_WIDTH, 24: accumulator, bias and output width (signed); must be greater than SUM_WIDTH.
- CH_WIDTH, 8: width of the channel-count field.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous, active-low reset.
- cfg_vld  in  1  start pulse; sampled only in IDLE.
- cfg_num_ch  in  CH_WIDTH  number of input channels for this pixel.
- cfg_bias  in  ACC_WIDTH  signed bias; initial accumulator value.
- busy  out  1  high whenever state is not IDLE.
- win_vld  in  1  window/weight data valid, from fetch logic.
- win_rdy  out  1  controller accepts a window.
- dot_in_vld  out  1  connects to the dot unit's `in_vld`.
- dot_ans  in  SUM_WIDTH  signed `ans` from the dot unit.
- out_vld  out  1  output pixel valid.
- out_rdy  in  1  downstream accepts the pixel.
- out_data  out  ACC_WIDTH  signed saturated sum.
- out_ovf  out  1  sticky flag: saturation occurred during this pixel.

Behaviour:
- Reset (`rst_n` = 0 at a clk edge):
  - state = IDLE; acc, channel count, issue count, `ans_vld_q` and `out_ovf` all cleared.
  - Outputs: `busy`=0, `win_rdy`=0, `dot_in_vld`=0, `out_vld`=0, `out_data`=0, `out_ovf`=0.
  - Reset mid-operation discards the pixel in progress, with no output.
- States: IDLE, RUN, DRAIN, OUT.
- IDLE:
  - `cfg_vld`=1 latches `cfg_num_ch`, sets acc=`cfg_bias`, clears ovf and issue count.
  - If `cfg_num_ch`=0, go to OUT (`out_data`=bias on the next cycle); otherwise go to RUN.
- RUN:
  - `win_rdy`=1 (registered-state decode only; no dependence on `win_vld`).
  - `dot_in_vld` = `win_vld` & `win_rdy`; an accepted window is a "fire".
  - Each fire increments the issue count. The fire that brings it to `num_ch` transitions to DRAIN.
  - `win_vld` gaps are allowed; the state stays in RUN.
- DRAIN:
  - `win_rdy`=0.
  - Stays exactly one cycle (the last `ans` is accumulated this cycle), then goes to OUT.
- OUT:
  - `out_vld`=1; `out_data`=acc and `out_ovf` are held stable until `out_rdy`=1.
  - `out_vld` & `out_rdy` → IDLE; `out_vld` is 0 on the following cycle.
- Dot-unit timing:
  - The unit registers products on `in_vld`, and `ans` is valid the cycle after a fire.
  - `ans_vld_q` <= fire. On each cycle with `ans_vld_q`=1, acc <= sat(acc + sext(`dot_ans`)).
  - When `ans_vld_q`=0 the controller ignores `dot_ans`; the unit holds stale products.
- Latency:
  - Last fire at cycle t: accumulation at t+1 (DRAIN), `out_vld`=1 at t+2.
  - Back-to-back pixels: the next `cfg_vld` is accepted in the IDLE cycle after the handshake.
- Arithmetic:
  - Compute the sum in ACC_WIDTH+1 bits.
  - If the result exceeds 2^(ACC_WIDTH-1)-1, clamp to that value; if below -2^(ACC_WIDTH-1), clamp to that value.
  - Any clamp sets `out_ovf` (sticky until the next cfg).
  - Saturation persists: later negative contributions start from the clamped value.
- `cfg_vld` while `busy` is ignored, with no error indication.
- `out_rdy` outside OUT is ignored.
- `win_vld` outside RUN: no fire, and `dot_in_vld`=0.

Decomposition:
- Shared package (`calc_pkg`):
  - State encodings (IDLE=0, RUN=1, DRAIN=2, OUT=3).
  - SUM_WIDTH/ACC_WIDTH defaults.
  - A saturating-add function shared with the future requant stage.
- One natural sub-module, `sat_acc`:
  - Signed accumulator with load (bias), enable, saturation and sticky ovf.
  - The FSM and counters stay in `conv_chan_acc_ctrl`.

Test Plan:
1. Reset → reset values:
   - Assert `rst_n`=0 for 2 cycles with `win_vld`=1, `cfg_vld`=1.
   - All outputs 0; `busy`=0; no fire.
2. Basic 3-channel pixel:
   - cfg `num_ch`=3, `bias`=10; `ans` sequence 100, -50, 7 with `win_vld` continuously high.
   - Exactly 3 `dot_in_vld` pulses; `out_vld` 2 cycles after the 3rd fire; `out_data`=67, `out_ovf`=0.
3. Bubbles and backpressure:
   - Same as test 2 with `win_vld` gaps of 2 cycles, then hold `out_rdy`=0 for 5 cycles.
   - `out_data`=67 stable throughout; return to IDLE the cycle after `out_rdy`=1.
4. Positive saturation:
   - `num_ch`=60, `bias`=0, each `ans`=147456 (all int8 -128×-128).
   - `out_data`=8388607, `out_ovf`=1.
5. Negative saturation:
   - `num_ch`=60, each `ans`=-146304.
   - `out_data`=-8388608, `out_ovf`=1.
6. Zero channels and ignored cfg:
   - `num_ch`=0, `bias`=-5 → `out_vld` the cycle after cfg, `out_data`=-5, `win_rdy` never 1.
   - Pulse `cfg_vld` during RUN of a 4-channel pixel → ignored; the result is unaffected.
   - Reset mid-RUN → no `out_vld`; the next pixel is correct.
